// File: rtl/motor_pwm_tach_nch.sv
// motor_pwm_tach_nch: N-channel PWM enable with dead-time direction switching and windowed tach counts
module motor_pwm_tach_nch #(
    parameter int NCH      = 2,
    parameter int DUTY_W   = 8,
    parameter int PRESCALE = 4,
    parameter int DEAD_CYC = 1000,
    parameter int WIN_CYC  = 10000000,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NCH*DUTY_W-1:0] duty,
    input  logic [NCH-1:0]        dir_req,
    input  logic [NCH-1:0]        sa,
    output logic [NCH-1:0]        en,
    output logic [NCH-1:0]        dir,
    output logic [NCH*CNT_W-1:0]  rpm_cnt,
    output logic                  cnt_valid,
    output logic [NCH-1:0]        brake_busy
);
    localparam int PS_W  = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int DD_W  = DEAD_CYC > 1 ? $clog2(DEAD_CYC) : 1;
    localparam int WIN_W = $clog2(WIN_CYC);

    typedef enum logic [1:0] {RUN, BRAKE, SWITCH} st_e;

    logic [PS_W-1:0]   ps_cnt;
    logic [DUTY_W-1:0] pwm_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic              tick, per_end, win_end;

    assign tick    = ps_cnt == PS_W'(PRESCALE - 1);
    assign per_end = tick && (pwm_cnt == '1);
    assign win_end = win_cnt == WIN_W'(WIN_CYC - 1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ps_cnt    <= '0;
            pwm_cnt   <= '0;
            win_cnt   <= '0;
            cnt_valid <= 1'b0;
        end else begin
            ps_cnt    <= tick ? '0 : ps_cnt + 1'b1;
            pwm_cnt   <= pwm_cnt + DUTY_W'(tick);
            win_cnt   <= win_end ? '0 : win_cnt + 1'b1;
            cnt_valid <= win_end;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        st_e               state, state_nxt;
        logic [DD_W-1:0]   dead;
        logic [DUTY_W-1:0] duty_lat;
        logic              en_q, dir_q, busy_q, en_nxt, dir_nxt;
        logic [2:0]        sync;
        logic              rise;
        logic [CNT_W-1:0]  edge_cnt, edge_inc, rpm_q;

        assign rise     = sync[1] & ~sync[2];
        assign edge_inc = (edge_cnt == '1) ? edge_cnt : edge_cnt + CNT_W'(rise);

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state <= RUN;
                dead  <= '0;
            end else begin
                state <= state_nxt;
                dead  <= (state == BRAKE) ? dead + 1'b1 : '0;
            end
        end

        // A request toggling during BRAKE never restarts the dead time; SWITCH just applies whatever is requested then.
        always_comb begin
            state_nxt = (state == RUN)   ? ((dir_req[k] != dir_q) ? BRAKE : RUN) :
                        (state == BRAKE) ? ((dead == DD_W'(DEAD_CYC - 1)) ? SWITCH : BRAKE) : RUN;
        end

        always_comb begin
            en_nxt  = (pwm_cnt < duty_lat) && (state == RUN);
            dir_nxt = (state == SWITCH) ? dir_req[k] : dir_q;
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                {en_q, dir_q, busy_q} <= '0;
                duty_lat              <= '0;
                sync                  <= '0;
                edge_cnt              <= '0;
                rpm_q                 <= '0;
            end else begin
                en_q     <= en_nxt;
                dir_q    <= dir_nxt;
                busy_q   <= state != RUN;
                duty_lat <= per_end ? duty[k*DUTY_W +: DUTY_W] : duty_lat;
                sync     <= {sync[1:0], sa[k]};
                edge_cnt <= win_end ? '0 : edge_inc;
                rpm_q    <= win_end ? edge_inc : rpm_q;
            end
        end

        assign en[k]                     = en_q;
        assign dir[k]                    = dir_q;
        assign brake_busy[k]             = busy_q;
        assign rpm_cnt[k*CNT_W +: CNT_W] = rpm_q;
    end
endmodule

// File: tb/tb_motor_pwm_tach_nch.sv
// tb_motor_pwm_tach_nch: scoreboard bench; stimulus queues expected ranges and window counts, a monitor checks them.
`timescale 1ns/1ps
module tb_motor_pwm_tach_nch;
    logic        clk = 0;
    logic        resetn = 0;
    logic [15:0] duty = 16'h0040;
    logic [1:0]  dir_req = 0;
    logic [1:0]  sa = 0;
    logic [1:0]  en, dir, brake_busy;
    logic [15:0] rpm_cnt;
    logic        cnt_valid;

    motor_pwm_tach_nch #(
        .NCH(2), .DUTY_W(8), .PRESCALE(1), .DEAD_CYC(20), .WIN_CYC(1000), .CNT_W(8)
    ) dut (
        .clk(clk), .resetn(resetn), .duty(duty), .dir_req(dir_req), .sa(sa),
        .en(en), .dir(dir), .rpm_cnt(rpm_cnt), .cnt_valid(cnt_valid), .brake_busy(brake_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [15:0] mask;
        logic [15:0] exp;
        int          lo;
        int          hi;
        bit          bad;
        logic [15:0] got;
        int          at;
    } chk_t;

    typedef struct {
        int          at;
        logic [15:0] v;
    } win_t;

    chk_t  chk_q[$];
    string name_q[$];
    win_t  win_q[$];
    int    passed = 0;
    int    total = 0;
    int    ec = 0;
    bit    rel = 0;

    // ec counts clock edges since the first reset release; the DUT's counters equal ec modulo their periods.
    always @(posedge clk) if (rel) ec <= ec + 1;

    function automatic logic [15:0] sig(input int s);
        return s == 0 ? {14'b0, en} : s == 1 ? {14'b0, dir} : s == 2 ? {14'b0, brake_busy} :
               s == 3 ? rpm_cnt : {15'b0, cnt_valid};
    endfunction

    task automatic expect_rng(input string n, input int s, input logic [15:0] m,
                              input logic [15:0] e, input int lo, input int hi);
        chk_t c;
        c.sel = s; c.mask = m; c.exp = e; c.lo = lo; c.hi = hi; c.bad = 0; c.got = 0; c.at = 0;
        chk_q.push_back(c);
        name_q.push_back(n);
    endtask

    task automatic expect_win(input int at, input logic [7:0] c0, input logic [7:0] c1);
        win_t w;
        w.at = at; w.v = {c1, c0};
        win_q.push_back(w);
    endtask

    task automatic wait_ec(input int t);
        while (ec != t) @(negedge clk);
    endtask

    always @(negedge clk) begin
        chk_t        c;
        win_t        w;
        logic [15:0] v;
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            c = chk_q[i];
            if (ec >= c.lo && ec <= c.hi) begin
                v = sig(c.sel) & c.mask;
                if (v !== c.exp && !c.bad) begin
                    c.bad = 1; c.got = v; c.at = ec;
                end
                chk_q[i] = c;
                if (ec == c.hi) begin
                    total++;
                    if (c.bad) $display("FAIL %s: cycle %0d got %h, expected %h", name_q[i], c.at, c.got, c.exp);
                    else passed++;
                    chk_q.delete(i);
                    name_q.delete(i);
                end
            end
        end
        if (cnt_valid === 1'b1) begin
            total++;
            if (win_q.size() == 0) begin
                $display("FAIL window: unexpected cnt_valid at cycle %0d, rpm_cnt %h", ec, rpm_cnt);
            end else begin
                w = win_q.pop_front();
                if (w.at == ec && rpm_cnt === w.v) passed++;
                else $display("FAIL window: cycle %0d rpm_cnt %h, expected cycle %0d rpm_cnt %h", ec, rpm_cnt, w.at, w.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, cycle %0d", ec);
        $fatal(1, "timeout");
    end

    initial begin
        expect_win(1000, 0, 0);
        expect_win(2000, 0, 0);
        expect_win(3000, 0, 37);
        expect_win(4000, 0, 0);
        expect_win(5000, 255, 0);
        expect_win(6000, 1, 0);
        expect_win(7000, 0, 1);
        wait_ec(2010);
        repeat (37) begin
            sa[1] = 1; repeat (4) @(negedge clk);
            sa[1] = 0; repeat (4) @(negedge clk);
        end
        wait_ec(4005);
        repeat (300) begin
            sa[0] = 1; @(negedge clk);
            sa[0] = 0; @(negedge clk);
        end
        wait_ec(5997);
        sa[0] = 1;
        @(negedge clk);
        sa[1] = 1;
        wait_ec(6005);
        sa = 0;
    end

    initial begin
        expect_rng("reset_en", 0, 16'h3, 16'h0, 0, 0);
        expect_rng("reset_dir", 1, 16'h3, 16'h0, 0, 0);
        expect_rng("reset_busy", 2, 16'h3, 16'h0, 0, 0);
        expect_rng("reset_rpm", 3, 16'hffff, 16'h0, 0, 0);
        expect_rng("reset_valid", 4, 16'h1, 16'h0, 0, 0);
        repeat (3) @(negedge clk);
        resetn = 1;
        rel = 1;

        expect_rng("t1_en0_first_period", 0, 16'h1, 16'h0, 1, 256);
        for (int p = 1; p <= 3; p++) begin
            expect_rng($sformatf("t1_en0_high_p%0d", p), 0, 16'h1, 16'h1, 256*p + 1, 256*p + 64);
            expect_rng($sformatf("t1_en0_low_p%0d", p), 0, 16'h1, 16'h0, 256*p + 65, 256*p + 256);
        end
        expect_rng("t1_en1_off", 0, 16'h2, 16'h0, 1, 1024);

        expect_rng("t2_en0_high_old", 0, 16'h1, 16'h1, 1025, 1088);
        expect_rng("t2_en0_low_old", 0, 16'h1, 16'h0, 1089, 1280);
        expect_rng("t2_en0_high_new", 0, 16'h1, 16'h1, 1281, 1472);
        expect_rng("t2_en0_low_new", 0, 16'h1, 16'h0, 1473, 1536);
        wait_ec(1124);
        duty[7:0] = 8'd192;

        expect_rng("t3_en0_before", 0, 16'h1, 16'h1, 1537, 1541);
        expect_rng("t3_en0_dead", 0, 16'h1, 16'h0, 1542, 1562);
        expect_rng("t3_en0_resume", 0, 16'h1, 16'h1, 1563, 1728);
        expect_rng("t3_dir0_old", 1, 16'h1, 16'h0, 1537, 1561);
        expect_rng("t3_dir0_new", 1, 16'h1, 16'h1, 1562, 1600);
        expect_rng("t3_busy0_idle", 2, 16'h1, 16'h0, 1537, 1541);
        expect_rng("t3_busy0_high", 2, 16'h1, 16'h1, 1542, 1562);
        expect_rng("t3_busy0_done", 2, 16'h1, 16'h0, 1563, 1600);
        expect_rng("t3_ch1_en", 0, 16'h2, 16'h0, 1537, 1600);
        expect_rng("t3_ch1_dir", 1, 16'h2, 16'h0, 1537, 1600);
        expect_rng("t3_ch1_busy", 2, 16'h2, 16'h0, 1537, 1600);
        wait_ec(1540);
        dir_req[0] = 1;

        expect_rng("max_en1_old", 0, 16'h2, 16'h0, 1601, 1792);
        expect_rng("max_en1_high", 0, 16'h2, 16'h2, 1793, 2047);
        expect_rng("max_en1_low", 0, 16'h2, 16'h0, 2048, 2048);
        wait_ec(1600);
        duty[15:8] = 8'd255;

        expect_rng("t4_en1_before", 0, 16'h2, 16'h2, 2049, 2061);
        expect_rng("t4_en1_dead", 0, 16'h2, 16'h0, 2062, 2082);
        expect_rng("t4_en1_resume", 0, 16'h2, 16'h2, 2083, 2303);
        expect_rng("t4_busy1_idle", 2, 16'h2, 16'h0, 2049, 2061);
        expect_rng("t4_busy1_once", 2, 16'h2, 16'h2, 2062, 2082);
        expect_rng("t4_busy1_no_second", 2, 16'h2, 16'h0, 2083, 2200);
        expect_rng("t4_dir1_kept", 1, 16'h2, 16'h0, 2049, 2200);
        wait_ec(2060);
        dir_req[1] = 1;
        wait_ec(2063);
        dir_req[1] = 0;

        expect_rng("t6_rpm_held", 3, 16'hffff, 16'h0100, 7001, 7019);
        expect_rng("t6_busy0_brake", 2, 16'h1, 16'h1, 7012, 7019);
        expect_rng("t6_dir0_before", 1, 16'h1, 16'h1, 7012, 7019);
        expect_rng("t6_rst_en", 0, 16'h3, 16'h0, 7020, 7020);
        expect_rng("t6_rst_dir", 1, 16'h3, 16'h0, 7020, 7020);
        expect_rng("t6_rst_busy", 2, 16'h3, 16'h0, 7020, 7020);
        expect_rng("t6_rst_rpm", 3, 16'hffff, 16'h0, 7020, 7020);
        expect_rng("t6_after_busy", 2, 16'h3, 16'h0, 7021, 7080);
        expect_rng("t6_after_dir", 1, 16'h3, 16'h0, 7021, 7080);
        expect_rng("t6_after_en", 0, 16'h3, 16'h0, 7021, 7080);
        expect_rng("t6_after_valid", 4, 16'h1, 16'h0, 7021, 7080);
        wait_ec(7010);
        dir_req[0] = 0;
        wait_ec(7019);
        @(posedge clk);
        #2 resetn = 0;
        wait_ec(7025);
        resetn = 1;

        wait_ec(7100);
        total++;
        if (chk_q.size() == 0 && win_q.size() == 0) passed++;
        else $display("FAIL leftover: %0d range checks and %0d windows never completed", chk_q.size(), win_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
